// File: rtl/miriscv_int_pkg.sv
// rtl/miriscv_int_pkg.sv - shared types and constants for the miriscv interrupt controller
package miriscv_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        FIN     = 2'd3
    } int_state_e;

    localparam int MCAUSE_INT_BIT = 31;
    localparam int N_IRQ_DEFAULT  = 32;

endpackage

// File: rtl/miriscv_rr_arbiter.sv
// rtl/miriscv_rr_arbiter.sv - combinational rotating-priority pick of one request
//   req_i   : candidate vector
//   ptr_i   : highest-priority index this round
//   valid_o : some bit of req_i is set
//   idx_o   : first set index at or above ptr_i, wrapping N-1 -> 0
module miriscv_rr_arbiter #(
    parameter int N    = 32,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            valid_o,
    output logic [ID_W-1:0] idx_o
);

    always_comb begin
        int j;
        j       = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan N positions starting at ptr_i; the first hit wins.
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/miriscv_int_ctrl.sv
// rtl/miriscv_int_ctrl.sv - interrupt controller: mask, round-robin pick, ack/mret handshake
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   int_req_i     : level device requests
//   mie_i         : enable mask
//   int_o         : interrupt request to the core
//   int_ack_i     : core entered the trap
//   mcause_o      : cause value (bit 31 set, low bits = index)
//   int_rst_i     : core executed mret
//   int_fin_o     : one-hot, one-cycle completion pulse
module miriscv_int_ctrl
    import miriscv_int_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    output logic             int_o,
    input  logic             int_ack_i,
    output logic [31:0]      mcause_o,
    input  logic             int_rst_i,
    output logic [N_IRQ-1:0] int_fin_o
);

    int_state_e       state_q,  state_d;
    logic [ID_W-1:0]  id_q,     id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             int_q,    int_d;
    logic [31:0]      mcause_q, mcause_d;
    logic [N_IRQ-1:0] fin_q,    fin_d;

    logic [N_IRQ-1:0] eligible;
    logic             arb_valid;
    logic [ID_W-1:0]  arb_idx;

    assign eligible = int_req_i & mie_i;

    miriscv_rr_arbiter #(
        .N    (N_IRQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        int_d    = int_q;
        mcause_d = mcause_q;
        fin_d    = '0;

        case (state_q)
            IDLE: begin
                int_d = 1'b0;
                if (arb_valid) begin
                    state_d                 = REQ;
                    id_d                    = arb_idx;
                    int_d                   = 1'b1;
                    mcause_d                = '0;
                    mcause_d[MCAUSE_INT_BIT] = 1'b1;
                    mcause_d[ID_W-1:0]      = arb_idx;
                end
            end
            REQ: begin
                int_d = 1'b1;
                // Ack takes precedence over a simultaneous withdraw.
                if (int_ack_i) begin
                    state_d = SERVICE;
                    int_d   = 1'b0;
                end else if (!eligible[id_q]) begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                end
            end
            SERVICE: begin
                int_d = 1'b0;
                if (int_rst_i) begin
                    state_d     = FIN;
                    fin_d[id_q] = 1'b1;
                end
            end
            FIN: begin
                state_d  = IDLE;
                rr_ptr_d = (id_q == ID_W'(N_IRQ - 1)) ? '0 : id_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            id_q     <= '0;
            rr_ptr_q <= '0;
            int_q    <= 1'b0;
            mcause_q <= '0;
            fin_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            int_q    <= int_d;
            mcause_q <= mcause_d;
            fin_q    <= fin_d;
        end
    end

    assign int_o     = int_q;
    assign mcause_o  = mcause_q;
    assign int_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// tb/tb_miriscv_int_ctrl.sv - directed self-checking bench for miriscv_int_ctrl
module tb_miriscv_int_ctrl;
    import miriscv_int_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] int_req_i;
    logic [31:0] mie_i;
    logic        int_o;
    logic        int_ack_i;
    logic [31:0] mcause_o;
    logic        int_rst_i;
    logic [31:0] int_fin_o;

    int checks = 0;
    int errors = 0;

    miriscv_int_ctrl #(.N_IRQ(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .int_req_i (int_req_i),
        .mie_i     (mie_i),
        .int_o     (int_o),
        .int_ack_i (int_ack_i),
        .mcause_o  (mcause_o),
        .int_rst_i (int_rst_i),
        .int_fin_o (int_fin_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int_state_e exp);
        chk(tag, 32'(dut.state_q), 32'(exp));
    endtask

    // Starts with the DUT presenting idx in REQ; ends back in IDLE after FIN.
    task automatic do_service(input int idx, input logic [31:0] req_after);
        chk("req_int_o", 32'(int_o), 32'd1);
        chk("req_mcause", mcause_o, 32'h8000_0000 | 32'(idx));
        int_ack_i = 1'b1;
        step();
        int_ack_i = 1'b0;
        int_req_i = req_after;
        chk("svc_int_o", 32'(int_o), 32'd0);
        chk_state("svc_state", SERVICE);
        chk("svc_mcause", mcause_o, 32'h8000_0000 | 32'(idx));
        int_rst_i = 1'b1;
        step();
        int_rst_i = 1'b0;
        chk("fin_pulse", int_fin_o, 32'd1 << idx);
        chk_state("fin_state", FIN);
        step();
        chk("fin_clear", int_fin_o, 32'd0);
        chk("rr_ptr", 32'(dut.rr_ptr_q), 32'((idx + 1) % 32));
    endtask

    initial begin
        int order [4];
        order = '{1, 2, 1, 2};

        rst_i     = 1'b1;
        int_req_i = '0;
        mie_i     = '0;
        int_ack_i = 1'b0;
        int_rst_i = 1'b0;
        repeat (2) step();
        chk("rst_int_o", 32'(int_o), 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        chk("rst_fin", int_fin_o, 32'd0);
        chk_state("rst_state", IDLE);
        rst_i = 1'b0;
        step();

        // Single request on line 5
        mie_i     = 32'hFFFF_FFFF;
        int_req_i = 32'h0000_0020;
        step();
        do_service(5, 32'd0);

        // Masked request stays invisible until enabled
        mie_i     = 32'd0;
        int_req_i = 32'h0000_0008;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("mask_int_o", 32'(int_o), 32'd0);
        end
        mie_i = 32'h0000_0008;
        step();
        do_service(3, 32'd0);

        // Round-robin between lines 1 and 2 (rr_ptr starts at 4)
        mie_i     = 32'hFFFF_FFFF;
        int_req_i = 32'h0000_0006;
        for (int k = 0; k < 4; k++) begin
            step();
            do_service(order[k], 32'h0000_0006);
        end
        int_req_i = 32'd0;

        // Withdraw in REQ: no completion pulse, pointer untouched
        int_req_i = 32'h0000_0080;
        step();
        chk("wd_int_o", 32'(int_o), 32'd1);
        chk("wd_mcause", mcause_o, 32'h8000_0007);
        int_req_i = 32'd0;
        step();
        chk("wd_drop", 32'(int_o), 32'd0);
        chk_state("wd_state", IDLE);
        chk("wd_fin", int_fin_o, 32'd0);
        step();
        chk("wd_fin2", int_fin_o, 32'd0);
        chk("wd_rr", 32'(dut.rr_ptr_q), 32'd3);
        int_req_i = 32'h0000_0001;
        step();
        do_service(0, 32'd0);

        // Ack outside REQ is ignored
        int_ack_i = 1'b1;
        step();
        int_ack_i = 1'b0;
        chk("ack_idle_int_o", 32'(int_o), 32'd0);
        chk_state("ack_idle_state", IDLE);

        // Line 9 raised during service of line 4 waits for the completion
        int_req_i = 32'h0000_0010;
        step();
        do_service(4, 32'h0000_0200);
        chk("nest_wait", 32'(int_o), 32'd0);
        step();
        chk("nest_int_o", 32'(int_o), 32'd1);
        chk("nest_mcause", mcause_o, 32'h8000_0009);

        // Ack and withdraw in the same cycle: ack wins
        int_req_i = 32'd0;
        int_ack_i = 1'b1;
        step();
        int_ack_i = 1'b0;
        chk_state("ackwd_state", SERVICE);
        chk("ackwd_int_o", 32'(int_o), 32'd0);
        int_rst_i = 1'b1;
        step();
        int_rst_i = 1'b0;
        chk("ackwd_fin", int_fin_o, 32'h0000_0200);
        step();
        chk("ackwd_rr", 32'(dut.rr_ptr_q), 32'd10);

        // Reset in SERVICE; pointer restarts at 0
        int_req_i = 32'h0000_1008;
        step();
        chk("pre_rst_mcause", mcause_o, 32'h8000_000C);
        int_rst_i = 1'b1;
        step();
        int_rst_i = 1'b0;
        chk_state("mret_in_req", REQ);
        chk("mret_in_req_int_o", 32'(int_o), 32'd1);
        int_ack_i = 1'b1;
        step();
        int_ack_i = 1'b0;
        chk_state("pre_rst_state", SERVICE);
        rst_i = 1'b1;
        #1;
        chk("arst_int_o", 32'(int_o), 32'd0);
        chk("arst_mcause", mcause_o, 32'd0);
        chk("arst_fin", int_fin_o, 32'd0);
        chk_state("arst_state", IDLE);
        chk("arst_rr", 32'(dut.rr_ptr_q), 32'd0);
        step();
        chk("rst_hold_int_o", 32'(int_o), 32'd0);
        rst_i = 1'b0;
        step();
        chk("post_rst_int_o", 32'(int_o), 32'd1);
        chk("post_rst_mcause", mcause_o, 32'h8000_0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
